// File: rtl/aes_fifo_host_bridge.sv
// Host-side driver for the FIFO-wrapped AES core: buffers (data,key) pairs, streams them
// into the AES input FIFO with an end tag on the last word, then collects the result bytes.
module aes_fifo_host_bridge #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_PAIRS  = 16,
    parameter logic [15:0] LAST_TAG   = 16'h1111
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_wr,
    input  logic [$clog2(NUM_PAIRS)-1:0] cfg_addr,
    input  logic [15:0]                  cfg_wdata,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(NUM_PAIRS):0]   rx_count,
    input  logic [$clog2(NUM_PAIRS)-1:0] res_rd_addr,
    output logic [7:0]                   res_rd_data,
    input  logic                         in_full,
    output logic                         in_wr,
    output logic [DATA_WIDTH-1:0]        in_dout,
    input  logic                         out_empty,
    output logic                         out_rd,
    input  logic [DATA_WIDTH-1:0]        out_din
);

    localparam int IW = $clog2(NUM_PAIRS);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   tx_idx_reg;
    logic [CW-1:0]   rx_count_reg;
    logic            err_reg;
    logic [7:0]      res_rd_data_reg;
    logic [15:0]     pair_mem [NUM_PAIRS];
    logic [7:0]      res_mem  [NUM_PAIRS];
    logic [15:0]     tag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FIFO handshakes are combinational so a write/pop happens the same cycle the flag allows it
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        in_wr      = 1'b0;
        out_rd     = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                in_wr = !in_full;
                if (!in_full && tx_idx_reg == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_rd = !out_empty;
                if (!out_empty && rx_count_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_idx_reg   <= '0;
            rx_count_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                tx_idx_reg   <= '0;
                rx_count_reg <= '0;
                err_reg      <= 1'b0;
            end
            if (in_wr) begin
                tx_idx_reg <= tx_idx_reg + CW'(1);
            end
            if (out_rd) begin
                rx_count_reg <= rx_count_reg + CW'(1);
                if (|out_din[DATA_WIDTH-1:8]) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    // Pair buffer only accepts writes while idle so the words in flight stay stable
    always_ff @(posedge clock) begin
        if (state_reg == IDLE && cfg_wr) begin
            pair_mem[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (out_rd) begin
            res_mem[rx_count_reg[IW-1:0]] <= out_din[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_rd_data_reg <= '0;
        end else begin
            res_rd_data_reg <= res_mem[res_rd_addr];
        end
    end

    assign tag         = (tx_idx_reg == LAST_IDX) ? LAST_TAG : 16'h0000;
    assign in_dout     = DATA_WIDTH'({tag, pair_mem[tx_idx_reg[IW-1:0]]});
    assign rx_count    = rx_count_reg;
    assign err         = err_reg;
    assign res_rd_data = res_rd_data_reg;

endmodule

// File: doc/aes_fifo_host_bridge.md
# aes_fifo_host_bridge

Host-side driver for the FIFO-wrapped 8-bit AES user logic: buffers 16 (data, key) byte pairs written over a simple config port, pushes them as 32-bit words into the AES input FIFO (last word end-tagged), then drains 16 result words from the AES output FIFO into a result buffer readable by the host. Sits between the host register/config logic and the input/output FIFO pair of the AES block, on the same clock.

## Interface
- DATA_WIDTH, 32, FIFO word width
- NUM_PAIRS, 16, pairs per block (counters are $clog2(NUM_PAIRS)+1 bits)
- LAST_TAG, 16'h1111, bits [31:16] of the final input word; all other words carry 16'h0000

- clock  in  1  sole clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- cfg_wr  in  1  write one pair slot
- cfg_addr  in  4  pair slot index 0..15
- cfg_wdata  in  16  {key[15:8], data[7:0]}
- start  in  1  single-cycle pulse, begin a block
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the 16th result is stored
- err  out  1  sticky; set when a received word has out_din[31:8] != 0; cleared by start or reset
- rx_count  out  5  results stored in the current block
- res_rd_addr  in  4  result slot index
- res_rd_data  out  8  registered result byte, 1-cycle read latency
- in_full  in  1  AES input FIFO full
- in_wr  out  1  AES input FIFO write enable
- in_dout  out  DATA_WIDTH  AES input FIFO write data
- out_empty  in  1  AES output FIFO empty (first-word-fall-through)
- out_rd  out  1  AES output FIFO pop
- out_din  in  DATA_WIDTH  AES output FIFO head word, valid while out_empty=0

## Operation
- States: IDLE, SEND, DRAIN, DONE.
- IDLE: cfg_wr stores cfg_wdata into pair[cfg_addr]. start -> SEND; tx_idx<=0, rx_count<=0, err<=0.
- SEND: in_wr = !in_full (combinational); in_dout = {tag, pair[tx_idx]}; tag = LAST_TAG when tx_idx==NUM_PAIRS-1, else 0. tx_idx increments on each accepted write (in_wr=1). The write at tx_idx==NUM_PAIRS-1 moves to DRAIN.
- DRAIN: out_rd = !out_empty (combinational); on each pop, res[rx_count] <= out_din[7:0], rx_count increments; err sets if out_din[31:8]!=0. The pop at rx_count==NUM_PAIRS-1 moves to DONE.
- DONE: done=1 for this cycle only, then IDLE.
- in_wr is 0 outside SEND; out_rd is 0 outside DRAIN. Words in the output FIFO while IDLE/SEND are left untouched.
- start while busy is ignored. cfg_wr while busy is ignored, so the pair buffer stays stable during SEND.
- res_rd_data <= res[res_rd_addr] every cycle in every state. Reading a slot while DRAIN writes it returns the old value.
- The output FIFO has depth >= NUM_PAIRS. The bridge never pops during SEND.
- Reset (async, any state): state=IDLE, busy=0, done=0, err=0, rx_count=0, tx_idx=0, res_rd_data=0, in_wr=0, out_rd=0. Pair and result buffers are not reset. Reset mid-block abandons the block; FIFO contents are the FIFOs' responsibility.

## Timing
- start sampled at cycle T -> busy=1 and SEND from T+1. Without backpressure, word i is written at T+1+i, and the tagged word at T+16.
- in_full=1 stalls SEND with no write and tx_idx held. Resumes the same cycle in_full falls.
- DRAIN starts at T+17 at the earliest. With out_empty=0 throughout, there are 16 pops at T+17..T+32, done at T+33, and IDLE/busy=0 at T+34.
- out_empty=1 in DRAIN stalls with no pop. There is no timeout; the block waits indefinitely.
- rx_count reaches 16 at the DONE cycle and holds until the next start.

## Test plan
- Load pair i = {key=8'h10+i, data=8'hA0+i}, start, no backpressure -> in_dout sequence 32'h0000_10A0 .. 32'h1111_1FAF on 16 consecutive cycles, done 33 cycles after start.
- Toggle in_full every other cycle during SEND -> no in_wr while full, same 16 words in order, tag only on the 16th.
- Output FIFO returns 32'h0000_00(i*3) with random empty gaps -> res[i] = i*3 readable via res_rd_addr one cycle later, rx_count=16, err=0.
- One returned word 32'h0000_010C -> err=1 and res byte 8'h0C; next start clears err.
- Assert reset during DRAIN after 5 pops -> busy=0, rx_count=0, out_rd=0 immediately. A new block then completes normally.
- start and cfg_wr asserted during SEND -> no restart, pair buffer unchanged, transmitted words match the original pairs.
